// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/bubble generation (mem busy > jump > multicycle > load-use).
// Optional performance counters are enabled with macro PIPE_HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int MC_W = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            d_use_rs,
    input  logic            d_use_rt,
    input  logic [4:0]      d_rs,
    input  logic [4:0]      d_rt,
    input  logic            e_wreg,
    input  logic            e_m2reg,
    input  logic [4:0]      e_rn,
    input  logic            e_mc_start,
    input  logic [MC_W-1:0] e_mc_cycles,
    input  logic            m_do_jmp,
    input  logic            m_mem_busy,
    output logic            f_stall,
    output logic            d_stall,
    output logic            e_stall,
    output logic            m_stall,
    output logic            d_bubble,
    output logic            e_bubble,
    output logic            m_bubble,
    output logic            w_bubble,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_flush_cnt,
`endif
    output logic            mc_busy
);

    typedef enum logic {RUN = 1'b0, MC = 1'b1} mc_state_e;

    mc_state_e       state_r, state_next_s;
    // Counter holds the number of MC-state cycles still to be spent, so an
    // N-cycle op costs one RUN cycle plus N-2 MC cycles (N-1 stall cycles total).
    logic [MC_W-1:0] cnt_r, cnt_next_s;

    logic f_stall_s, d_stall_s, e_stall_s, m_stall_s;
    logic d_bubble_s, e_bubble_s, m_bubble_s, w_bubble_s;
    logic load_use_s, jump_s;

    // Load-use detection; register 0 never creates a dependency
    always_comb begin
        load_use_s = e_wreg && e_m2reg && (e_rn != 5'd0) &&
                     ((d_use_rs && (d_rs == e_rn)) || (d_use_rt && (d_rt == e_rn)));
    end

    // Prioritised hazard resolution and FSM next-state
    always_comb begin
        f_stall_s    = 1'b0;
        d_stall_s    = 1'b0;
        e_stall_s    = 1'b0;
        m_stall_s    = 1'b0;
        d_bubble_s   = 1'b0;
        e_bubble_s   = 1'b0;
        m_bubble_s   = 1'b0;
        w_bubble_s   = 1'b0;
        jump_s       = 1'b0;
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        if (!resetn) begin
            state_next_s = RUN;
            cnt_next_s   = {MC_W{1'b0}};
        end else if (m_mem_busy) begin
            f_stall_s  = 1'b1;
            d_stall_s  = 1'b1;
            e_stall_s  = 1'b1;
            m_stall_s  = 1'b1;
            w_bubble_s = 1'b1;
        end else if (m_do_jmp) begin
            jump_s       = 1'b1;
            d_bubble_s   = 1'b1;
            e_bubble_s   = 1'b1;
            m_bubble_s   = 1'b1;
            state_next_s = RUN;
            cnt_next_s   = {MC_W{1'b0}};
        end else begin
            case (state_r)
                MC: begin
                    f_stall_s  = 1'b1;
                    d_stall_s  = 1'b1;
                    e_stall_s  = 1'b1;
                    m_bubble_s = 1'b1;
                    if (cnt_r <= MC_W'(1)) begin
                        state_next_s = RUN;
                        cnt_next_s   = {MC_W{1'b0}};
                    end else begin
                        cnt_next_s = cnt_r - MC_W'(1);
                    end
                end
                RUN: begin
                    if (e_mc_start && (e_mc_cycles >= MC_W'(2))) begin
                        f_stall_s  = 1'b1;
                        d_stall_s  = 1'b1;
                        e_stall_s  = 1'b1;
                        m_bubble_s = 1'b1;
                        cnt_next_s = e_mc_cycles - MC_W'(2);
                        if (e_mc_cycles == MC_W'(2)) begin
                            state_next_s = RUN;
                        end else begin
                            state_next_s = MC;
                        end
                    end else if (load_use_s) begin
                        f_stall_s  = 1'b1;
                        d_stall_s  = 1'b1;
                        e_bubble_s = 1'b1;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                default: begin
                    state_next_s = RUN;
                    cnt_next_s   = {MC_W{1'b0}};
                end
            endcase
        end
    end

    // Multicycle FSM state and counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= RUN;
            cnt_r   <= {MC_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_r, perf_flush_r;

    // Performance counters, free-running with natural wrap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_r <= 32'd0;
            perf_flush_r <= 32'd0;
        end else begin
            if (f_stall_s) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
            if (jump_s) begin
                perf_flush_r <= perf_flush_r + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_r;
    assign perf_flush_cnt    = perf_flush_r;
`endif

    assign f_stall  = f_stall_s;
    assign d_stall  = d_stall_s;
    assign e_stall  = e_stall_s;
    assign m_stall  = m_stall_s;
    assign d_bubble = d_bubble_s;
    assign e_bubble = e_bubble_s;
    assign m_bubble = m_bubble_s;
    assign w_bubble = w_bubble_s;
    assign mc_busy  = (state_r == MC);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed per-cycle vectors with hand-computed
// expected outputs {f,d,e,m_stall, d,e,m,w_bubble, mc_busy}.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       d_use_rs = 1'b0, d_use_rt = 1'b0;
    logic [4:0] d_rs = 5'd0, d_rt = 5'd0, e_rn = 5'd0;
    logic       e_wreg = 1'b0, e_m2reg = 1'b0, e_mc_start = 1'b0;
    logic [3:0] e_mc_cycles = 4'd0;
    logic       m_do_jmp = 1'b0, m_mem_busy = 1'b0;
    logic       f_stall, d_stall, e_stall, m_stall;
    logic       d_bubble, e_bubble, m_bubble, w_bubble, mc_busy;

    typedef struct {
        string      name;
        logic [8:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;

    pipeline_hazard_ctrl #(.MC_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_rs(d_rs), .d_rt(d_rt),
        .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_rn(e_rn),
        .e_mc_start(e_mc_start), .e_mc_cycles(e_mc_cycles),
        .m_do_jmp(m_do_jmp), .m_mem_busy(m_mem_busy),
        .f_stall(f_stall), .d_stall(d_stall), .e_stall(e_stall), .m_stall(m_stall),
        .d_bubble(d_bubble), .e_bubble(e_bubble), .m_bubble(m_bubble), .w_bubble(w_bubble),
        .mc_busy(mc_busy)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are valid every cycle; compare on the falling edge
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_entry_t e;
            logic [8:0] act;
            e   = sb_q.pop_front();
            act = {f_stall, d_stall, e_stall, m_stall, d_bubble, e_bubble, m_bubble, w_bubble, mc_busy};
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
            end
        end
    end

    // One cycle of stimulus (applied just after the rising edge) plus its expected response
    task automatic step(input string name, input logic rst, input logic use_rs, input logic use_rt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic wreg, input logic m2reg,
                        input logic [4:0] rn, input logic mcs, input logic [3:0] mcc,
                        input logic jmp, input logic busy, input logic [8:0] exp);
        sb_entry_t e;
        @(posedge clk);
        #1;
        resetn = rst; d_use_rs = use_rs; d_use_rt = use_rt; d_rs = rs; d_rt = rt;
        e_wreg = wreg; e_m2reg = m2reg; e_rn = rn; e_mc_start = mcs; e_mc_cycles = mcc;
        m_do_jmp = jmp; m_mem_busy = busy;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic idle(input string name, input logic [8:0] exp);
        step(name, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, exp);
    endtask

    task automatic mcop(input string name, input logic [3:0] n, input logic jmp, input logic busy,
                        input logic [8:0] exp);
        step(name, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, n, jmp, busy, exp);
    endtask

    localparam logic [8:0] NONE    = 9'b0000_0000_0;
    localparam logic [8:0] LU      = 9'b1100_0100_0;
    localparam logic [8:0] MC_RUN  = 9'b1110_0010_0;
    localparam logic [8:0] MC_BUSY = 9'b1110_0010_1;
    localparam logic [8:0] JMP     = 9'b0000_1110_0;
    localparam logic [8:0] JMP_MC  = 9'b0000_1110_1;
    localparam logic [8:0] MEM     = 9'b1111_0001_0;
    localparam logic [8:0] MEM_MC  = 9'b1111_0001_1;

    initial begin
        step("reset_state", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, NONE);
        idle("idle_after_reset", NONE);

        step("loaduse_rt5", 1'b1, 1'b0, 1'b1, 5'd0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 4'd0, 1'b0, 1'b0, LU);
        step("loaduse_r0", 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, NONE);
        step("loaduse_rs7", 1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 4'd0, 1'b0, 1'b0, LU);
        step("no_use_rs", 1'b1, 1'b0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 4'd0, 1'b0, 1'b0, NONE);
        step("not_load", 1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 4'd0, 1'b0, 1'b0, NONE);
        step("rt_mismatch", 1'b1, 1'b0, 1'b1, 5'd0, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 4'd0, 1'b0, 1'b0, NONE);

        // 4-cycle op: 3 stall cycles, mc_busy in the last 2
        mcop("mc4_c1", 4'd4, 1'b0, 1'b0, MC_RUN);
        mcop("mc4_c2", 4'd4, 1'b0, 1'b0, MC_BUSY);
        mcop("mc4_c3", 4'd4, 1'b0, 1'b0, MC_BUSY);
        idle("mc4_done", NONE);

        mcop("mc1_nostall", 4'd1, 1'b0, 1'b0, NONE);
        mcop("mc0_nostall", 4'd0, 1'b0, 1'b0, NONE);
        mcop("mc2_c1", 4'd2, 1'b0, 1'b0, MC_RUN);
        idle("mc2_done", NONE);

        // Jump on the 3rd cycle of an 8-cycle op
        mcop("mc8_c1", 4'd8, 1'b0, 1'b0, MC_RUN);
        mcop("mc8_c2", 4'd8, 1'b0, 1'b0, MC_BUSY);
        mcop("mc8_jmp", 4'd8, 1'b1, 1'b0, JMP_MC);
        idle("mc8_after_jmp", NONE);

        // Memory busy for 2 cycles inside a 4-cycle op: 5 e_stall cycles total
        mcop("mcmem_c1", 4'd4, 1'b0, 1'b0, MC_RUN);
        mcop("mcmem_busy1", 4'd4, 1'b0, 1'b1, MEM_MC);
        mcop("mcmem_busy2", 4'd4, 1'b0, 1'b1, MEM_MC);
        mcop("mcmem_c2", 4'd4, 1'b0, 1'b0, MC_BUSY);
        mcop("mcmem_c3", 4'd4, 1'b0, 1'b0, MC_BUSY);
        idle("mcmem_done", NONE);

        // Busy and jump together, then jump alone once busy drops
        step("busy_jmp", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b1, 1'b1, MEM);
        step("jmp_after_busy", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0, JMP);
        step("jmp_over_loaduse", 1'b1, 1'b0, 1'b1, 5'd0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 4'd0, 1'b1, 1'b0, JMP);
        step("mc_over_loaduse", 1'b1, 1'b0, 1'b1, 5'd0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 4'd2, 1'b0, 1'b0, MC_RUN);
        idle("idle_mid", NONE);

        // Reset in the middle of an op
        mcop("rst_mc_c1", 4'd8, 1'b0, 1'b0, MC_RUN);
        mcop("rst_mc_c2", 4'd8, 1'b0, 1'b0, MC_BUSY);
        step("rst_assert", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 4'd8, 1'b0, 1'b1, NONE);
        step("rst_held", 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 4'd0, 1'b1, 1'b0, NONE);
        idle("rst_release", NONE);
        idle("rst_idle", NONE);
        step("mem_busy_idle", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b1, MEM);
        idle("final_idle", NONE);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
